// File: rtl/pe_pkg.sv
// Shared types for the pe_dot dot-product processing element.
// Holds the FSM state encoding and the per-beat pipeline tag.
package pe_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic is_signed;
    } beat_tag_t;

endpackage

// File: rtl/pe_mult_stage.sv
// Registered BW x BW multiplier with a per-beat signed/unsigned select.
// Both operands are extended to 2*BW first, so one multiplier covers both modes.
module pe_mult_stage #(
    parameter int unsigned BW = 8
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic [BW-1:0]   i_a,
    input  logic [BW-1:0]   i_b,
    input  logic            i_is_signed,
    output logic [2*BW-1:0] o_product
);

    localparam int unsigned PW = 2 * BW;

    logic [PW-1:0] ext_a;
    logic [PW-1:0] ext_b;
    logic [PW-1:0] product_c;
    logic [PW-1:0] product_q;

    // The low 2*BW bits of the extended product are exact in either mode.
    always_comb begin
        ext_a = {{BW{1'b0}}, i_a};
        ext_b = {{BW{1'b0}}, i_b};
        if (i_is_signed) begin
            ext_a = {{BW{i_a[BW-1]}}, i_a};
            ext_b = {{BW{i_b[BW-1]}}, i_b};
        end
        product_c = PW'(ext_a * ext_b);
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            product_q <= '0;
        end else begin
            product_q <= product_c;
        end
    end

    assign o_product = product_q;

endmodule

// File: rtl/pe_dot.sv
// Pipelined length-K dot-product PE with systolic operand forwarding.
// Stage 1 registers/tags operands, stage 2 multiplies, stage 3 accumulates.
module pe_dot
    import pe_pkg::*;
#(
    parameter  int unsigned BW    = 8,
    parameter  int unsigned ACC_W = 2 * BW + 8,
    parameter  int unsigned K_MAX = 256,
    localparam int unsigned CNT_W = $clog2(K_MAX + 1)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic [BW-1:0]    i_activation,
    input  logic [BW-1:0]    i_weight,
    input  logic             i_signed,
    input  logic [CNT_W-1:0] i_len,
    output logic [BW-1:0]    o_activation,
    output logic [BW-1:0]    o_weight,
    output logic             o_valid,
    output logic [ACC_W-1:0] o_result,
    output logic             o_result_valid,
    output logic             o_busy
);

    localparam int unsigned PW = 2 * BW;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] len_eff;
    beat_tag_t        tag_c;

    beat_tag_t        tag1_q;
    beat_tag_t        tag2_q;
    logic [BW-1:0]    act_q;
    logic [BW-1:0]    wgt_q;
    logic [PW-1:0]    prod_q;

    logic [ACC_W-1:0] ext_c;
    logic [ACC_W-1:0] acc_sum_c;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] result_q;
    logic             result_valid_q;

    // Beat framing: decide first/last/mode for the incoming beat.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        mode_d  = mode_q;
        tag_c   = '0;
        len_eff = (i_len == '0) ? CNT_W'(1) : i_len;
        if (i_valid) begin
            tag_c.valid = 1'b1;
            case (state_q)
                IDLE: begin
                    tag_c.first     = 1'b1;
                    tag_c.is_signed = i_signed;
                    len_d           = len_eff;
                    mode_d          = i_signed;
                    count_d         = CNT_W'(1);
                    if (len_eff == CNT_W'(1)) begin
                        tag_c.last = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    tag_c.is_signed = mode_q;
                    count_d         = count_q + CNT_W'(1);
                    if (count_q == len_q - CNT_W'(1)) begin
                        tag_c.last = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q <= IDLE;
            count_q <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            act_q   <= '0;
            wgt_q   <= '0;
            tag1_q  <= '0;
            tag2_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            act_q   <= i_activation;
            wgt_q   <= i_weight;
            tag1_q  <= tag_c;
            tag2_q  <= tag1_q;
        end
    end

    pe_mult_stage #(
        .BW (BW)
    ) u_mult (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_a         (act_q),
        .i_b         (wgt_q),
        .i_is_signed (tag1_q.is_signed),
        .o_product   (prod_q)
    );

    // Extend the product to accumulator width and form the next sum.
    always_comb begin
        if (tag2_q.is_signed) begin
            ext_c = ACC_W'($signed(prod_q));
        end else begin
            ext_c = ACC_W'(prod_q);
        end
        acc_sum_c = tag2_q.first ? ext_c : acc_q + ext_c;
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            acc_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= tag2_q.valid & tag2_q.last;
            if (tag2_q.valid) begin
                acc_q <= acc_sum_c;
            end
            if (tag2_q.valid & tag2_q.last) begin
                result_q <= acc_sum_c;
            end
        end
    end

    assign o_activation   = act_q;
    assign o_weight       = wgt_q;
    assign o_valid        = tag1_q.valid;
    assign o_result       = result_q;
    assign o_result_valid = result_valid_q;
    assign o_busy         = (state_q == ACCUM) | tag1_q.valid | tag2_q.valid;

endmodule

// File: tb/tb_pe_dot.sv
// Bench for pe_dot: one 24-bit and one 16-bit accumulator instance share stimulus,
// a product-level model checks every cycle, literal expectations pin the model.
module tb_pe_dot;

    localparam int unsigned BW    = 8;
    localparam int unsigned CNT_W = 9;

    logic             i_clock = 1'b0;
    logic             i_reset;
    logic             i_valid;
    logic [BW-1:0]    i_activation;
    logic [BW-1:0]    i_weight;
    logic             i_signed;
    logic [CNT_W-1:0] i_len;

    logic [BW-1:0] a24, w24, a16, w16;
    logic          v24, v16, rv24, rv16, b24, b16;
    logic [23:0]   r24;
    logic [15:0]   r16;

    always #5 i_clock = ~i_clock;

    pe_dot #(.BW(8), .ACC_W(24), .K_MAX(256)) dut24 (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid),
        .i_activation(i_activation), .i_weight(i_weight), .i_signed(i_signed),
        .i_len(i_len), .o_activation(a24), .o_weight(w24), .o_valid(v24),
        .o_result(r24), .o_result_valid(rv24), .o_busy(b24)
    );

    pe_dot #(.BW(8), .ACC_W(16), .K_MAX(256)) dut16 (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid),
        .i_activation(i_activation), .i_weight(i_weight), .i_signed(i_signed),
        .i_len(i_len), .o_activation(a16), .o_weight(w16), .o_valid(v16),
        .o_result(r16), .o_result_valid(rv16), .o_busy(b16)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Product-level model: sums products per dot product, results due two edges after the last beat.
    typedef struct { int due; longint val; } pend_t;
    pend_t pq[$];
    bit        in_prod = 1'b0;
    bit        pmode;
    longint    sum;
    int        cnt, plen;
    logic [7:0] exp_a = '0, exp_w = '0;
    bit        exp_v = 0, vd1 = 0, vd2 = 0, exp_rv = 0, exp_busy = 0;
    longint    exp_res = 0;

    initial forever begin
        @(posedge i_clock);
        cyc++;
        if (!i_reset) begin
            in_prod = 0; pq.delete();
            exp_a = '0; exp_w = '0; exp_v = 0; vd1 = 0; vd2 = 0;
            exp_rv = 0; exp_res = 0;
        end else begin
            vd2 = vd1; vd1 = i_valid;
            exp_a = i_activation; exp_w = i_weight; exp_v = i_valid;
            if (i_valid) begin
                if (!in_prod) begin
                    in_prod = 1; sum = 0; cnt = 0;
                    plen  = (i_len == 0) ? 1 : int'(i_len);
                    pmode = i_signed;
                end
                if (pmode)
                    sum += longint'($signed(i_activation)) * longint'($signed(i_weight));
                else
                    sum += longint'(i_activation) * longint'(i_weight);
                cnt++;
                if (cnt == plen) begin
                    pq.push_back('{cyc + 2, sum});
                    in_prod = 0;
                end
            end
            exp_rv = 0;
            if (pq.size() > 0 && pq[0].due == cyc) begin
                exp_rv  = 1;
                exp_res = pq[0].val;
                void'(pq.pop_front());
            end
        end
        exp_busy = in_prod | vd1 | vd2;
    end

    // Per-cycle compare against the model, plus a log of result pulses.
    typedef struct { int c; logic [23:0] r24; logic [15:0] r16; } log_t;
    log_t rlog[$];

    initial forever begin
        @(negedge i_clock);
        if (cyc > 0) begin
            chk("fwd_a24", 64'(a24), 64'(exp_a));
            chk("fwd_w24", 64'(w24), 64'(exp_w));
            chk("fwd_v24", 64'(v24), 64'(exp_v));
            chk("fwd_a16", 64'(a16), 64'(exp_a));
            chk("fwd_w16", 64'(w16), 64'(exp_w));
            chk("fwd_v16", 64'(v16), 64'(exp_v));
            chk("rv24", 64'(rv24), 64'(exp_rv));
            chk("rv16", 64'(rv16), 64'(exp_rv));
            chk("res24", 64'(r24), 64'(exp_res) & 64'hFF_FFFF);
            chk("res16", 64'(r16), 64'(exp_res) & 64'hFFFF);
            chk("busy24", 64'(b24), 64'(exp_busy));
            chk("busy16", 64'(b16), 64'(exp_busy));
        end
        if (rv24 === 1'b1) rlog.push_back('{cyc, r24, r16});
    end

    int last_cap;

    task automatic drive(input bit v, input logic [7:0] a, input logic [7:0] w,
                         input bit s, input logic [CNT_W-1:0] l);
        i_valid = v; i_activation = a; i_weight = w; i_signed = s; i_len = l;
        last_cap = cyc + 1;
        @(posedge i_clock); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 8'h00, 8'h00, 0, 9'd0);
    endtask

    task automatic expect_log(input string name, input int idx, input int c,
                              input logic [23:0] e24, input logic [15:0] e16);
        if (rlog.size() > idx) begin
            chk({name, "_cycle"}, 64'(rlog[idx].c), 64'(c));
            chk({name, "_r24"}, 64'(rlog[idx].r24), 64'(e24));
            chk({name, "_r16"}, 64'(rlog[idx].r16), 64'(e16));
        end else begin
            chk({name, "_missing"}, 64'(rlog.size()), 64'(idx + 1));
        end
    endtask

    int c0;

    initial begin
        i_reset = 1'b0;
        i_valid = 0; i_activation = '0; i_weight = '0; i_signed = 0; i_len = '0;
        repeat (3) @(posedge i_clock);
        #1;
        i_reset = 1'b1;
        chk("reset_r24", 64'(r24), 64'd0);
        chk("reset_rv24", 64'(rv24), 64'd0);
        chk("reset_busy24", 64'(b24), 64'd0);
        chk("reset_v24", 64'(v24), 64'd0);
        idle(2);

        // Unsigned K=4: 1*5+2*6+3*7+4*8 = 70
        rlog.delete();
        drive(1, 8'd1, 8'd5, 0, 9'd4);
        drive(1, 8'd2, 8'd6, 0, 9'd4);
        drive(1, 8'd3, 8'd7, 0, 9'd4);
        drive(1, 8'd4, 8'd8, 0, 9'd4);
        c0 = last_cap;
        idle(6);
        expect_log("k4", 0, c0 + 2, 24'd70, 16'd70);
        chk("k4_count", 64'(rlog.size()), 64'd1);

        // Signed then unsigned K=2 on the same bytes, back to back
        rlog.delete();
        drive(1, 8'hFD, 8'h04, 1, 9'd2);
        drive(1, 8'h7F, 8'hFF, 1, 9'd2);
        c0 = last_cap;
        drive(1, 8'hFD, 8'h04, 0, 9'd2);
        drive(1, 8'h7F, 8'hFF, 0, 9'd2);
        idle(6);
        expect_log("sgn", 0, c0 + 2, 24'hFFFF75, 16'hFF75);
        expect_log("uns", 1, c0 + 4, 24'd33397, 16'd33397);

        // K=1 continuous stream: one result per cycle
        rlog.delete();
        c0 = cyc + 1;
        for (int i = 1; i <= 5; i++) drive(1, 8'(i), 8'd2, 0, 9'd1);
        idle(6);
        for (int i = 0; i < 5; i++)
            expect_log("k1", i, c0 + 2 + i, 24'(2 * (i + 1)), 16'(2 * (i + 1)));
        chk("k1_busy_drained", 64'(b24), 64'd0);

        // K=3 with gaps; len/mode changes after the first beat are ignored
        rlog.delete();
        drive(1, 8'hFE, 8'h03, 1, 9'd3);
        idle(1);
        drive(1, 8'h05, 8'hFF, 0, 9'd7);
        idle(2);
        drive(1, 8'h80, 8'h02, 0, 9'd1);
        c0 = last_cap;
        idle(6);
        expect_log("gap", 0, c0 + 2, 24'hFFFEF5, 16'hFEF5);
        chk("gap_count", 64'(rlog.size()), 64'd1);

        // Reset after 2 of 4 beats discards the partial sum
        rlog.delete();
        drive(1, 8'd1, 8'd1, 1, 9'd4);
        drive(1, 8'd2, 8'd2, 1, 9'd4);
        i_reset = 1'b0;
        idle(1);
        i_reset = 1'b1;
        idle(5);
        chk("rst_no_result", 64'(rlog.size()), 64'd0);
        chk("rst_r24", 64'(r24), 64'd0);
        chk("rst_r16", 64'(r16), 64'd0);
        drive(1, 8'd3, 8'd3, 0, 9'd1);
        c0 = last_cap;
        idle(5);
        expect_log("post_rst", 0, c0 + 2, 24'd9, 16'd9);

        // Wrap in the 16-bit accumulator, then i_len=0 as a single beat
        rlog.delete();
        drive(1, 8'd255, 8'd255, 0, 9'd2);
        drive(1, 8'd255, 8'd255, 0, 9'd2);
        c0 = last_cap;
        drive(1, 8'd7, 8'd6, 0, 9'd0);
        idle(6);
        expect_log("wrap", 0, c0 + 2, 24'd130050, 16'd64514);
        expect_log("len0", 1, c0 + 3, 24'd42, 16'd42);
        chk("final_busy", 64'(b16), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_dot.md
Name: pe_dot

Overview:
- Parametrised successor to the single-MAC processing element.
- Pipelined multiply-accumulate PE that computes length-K dot products over a valid-qualified operand stream.
- Supports per-product signed/unsigned mode, a configurable accumulator width, back-to-back products with no bubble, and an explicit result-valid pulse.
- Registers and forwards operands to neighbouring PEs so instances tile into a systolic row or array.

Parameters:
- BW, 8, operand width (activation and weight).
- ACC_W, 2*BW+8, accumulator/result width; must be >= 2*BW.
- K_MAX, 256, maximum dot-product length.
- CNT_W, $clog2(K_MAX+1), localparam; width of length/count fields.

Ports:
- i_clock  in  1  single clock, rising edge.
- i_reset  in  1  reset, synchronous, active-low.
- i_valid  in  1  operand pair valid this cycle.
- i_activation  in  BW  activation operand.
- i_weight  in  BW  weight operand.
- i_signed  in  1  1 = two's-complement operands; sampled on the first beat of a product only.
- i_len  in  CNT_W  product length K; sampled on the first beat only; 0 is treated as 1.
- o_activation  out  BW  i_activation delayed by 1 cycle (systolic forward).
- o_weight  out  BW  i_weight delayed by 1 cycle.
- o_valid  out  1  i_valid delayed by 1 cycle.
- o_result  out  ACC_W  completed dot product; holds until the next result.
- o_result_valid  out  1  one-cycle pulse when o_result updates.
- o_busy  out  1  high while a product is in progress or beats are in flight.

Behaviour:
- Reset: i_reset is synchronous and active-low, sampled on the i_clock rising edge. While low, every register clears to 0: state=IDLE, count, all pipeline valid/first/last/mode tags, product, acc, o_result, o_result_valid, o_activation, o_weight, o_valid.
- Reset mid-product discards the partial sum and emits no result.
- Stage 1 (edge E1): operands and i_valid registered every cycle, whether or not i_valid is high. These registers drive o_activation/o_weight/o_valid.
- Stage 1 also tags each beat with first, last and mode.
- Stage 2 (E2): product of the stage-1 operands registered at 2*BW bits, signed or unsigned per the beat's mode tag.
- Stage 3 (E3): the product is sign- or zero-extended to ACC_W.
  - first beat: acc <= ext(p); otherwise acc <= acc + ext(p).
  - Arithmetic wraps modulo 2^ACC_W; no saturation.
  - last beat: o_result <= the new acc value and o_result_valid <= 1 for exactly one cycle.
- Latency: last operand at input in cycle t gives o_result_valid high in cycle t+3.
- FSM:
  - IDLE: a valid beat is the first beat. Latch len = max(i_len,1) and mode = i_signed; count <= 1.
    - If len == 1, the beat is also last and the FSM stays in IDLE.
    - Otherwise go to ACCUM.
  - ACCUM: each valid beat increments count. The beat with count == len-1 is last and returns the FSM to IDLE.
  - Invalid cycles hold count and state; bubbles are allowed anywhere.
- i_signed and i_len changes during ACCUM are ignored.
- Mode travels with each beat, so back-to-back products with different modes are each correct.
- Back-to-back: a valid beat in the cycle after a last beat starts a new product with no bubble. first/last tags allow a K=1 stream to produce one result per cycle.
- o_busy = (state == ACCUM) | any stage-1/2 valid tag.
- o_result holds its value between pulses.

Decomposition:
- Package pe_pkg: state enum (IDLE, ACCUM) and a beat-tag struct {valid, first, last, is_signed}.
- Sub-module pe_mult_stage: the stage-2 registered multiplier with a signed/unsigned select, BW-parameterised.
- The FSM, counter and accumulator stay in pe_dot.

Test Plan:
- Unsigned, K=4: a=1,2,3,4, w=5,6,7,8 consecutive -> o_result=70, o_result_valid high exactly in cycle t+3 after the last beat, for one cycle.
- Signed, K=2, ACC_W=24: (0xFD,0x04),(0x7F,0xFF) -> o_result=0xFFFF75 (-139). Same bytes with i_signed=0 -> 33397 (0x008275).
- K=1, i_valid continuous, a=1..5, w=2 -> results 2,4,6,8,10 on five consecutive cycles; o_busy low after draining.
- K=3 with i_valid gaps, and i_len/i_signed toggled mid-product -> result equals the gapless computation using the first-beat len/mode. Forwarding: o_activation/o_weight/o_valid equal the inputs delayed 1 cycle every cycle.
- Reset held low 1 cycle after 2 of 4 beats -> no o_result_valid, o_result=0. Then K=1, a=3, w=3 -> 9.
- ACC_W=16 unsigned, K=2: (255,255) twice -> o_result=64514 (wrap of 130050). i_len=0 with a=7, w=6 -> 42 as a single-beat product.
